// File: rtl/bus_cycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : bus_cycle_ctrl
// Purpose  : Clocked 68000 bus-cycle sequencer. Latches the decoded region
//            when AS_n is first seen low, inserts the region's wait states
//            and returns DTACK_n. EXT cycles wait for the external device's
//            own acknowledge. Optionally times out stalled cycles with BERR_n.
// Revision : 1.0  initial release
//
// Ports
//   CLK          in   CPU clock, all state changes on the rising edge
//   RESET_n      in   synchronous active-low reset
//   AS_n         in   CPU address strobe (sampled directly, same clock domain)
//   BOOT         in   0 = boot phase, every cycle uses ROM timing
//   ROM_SEL      in   region decode: ROM
//   RAM_SEL      in   region decode: RAM
//   IO_SEL       in   region decode: on-board IO (fixed wait)
//   EXT_SEL      in   region decode: device supplying its own ack
//   EXT_DTACK_n  in   ack from the external device, active-low
//   DTACK_n      out  registered data-transfer ack to the CPU
//   BERR_n       out  registered bus error to the CPU
//   BUSY         out  registered, high while the sequencer is not idle
//
// Parameters
//   ROM_WAIT / RAM_WAIT / IO_WAIT  wait clocks per region (0..15)
//   BERR_TIMEOUT                   clocks from cycle start to BERR_n (1..255)
//
// Build option
//   BERR_TIMEOUT_EN  when defined, adds the timeout counter and ERR state.
//                    When undefined, BERR_n is tied high and unacked EXT or
//                    unmapped cycles wait until AS_n rises.
//------------------------------------------------------------------------------
`default_nettype none

module bus_cycle_ctrl #(
  parameter int ROM_WAIT     = 2,
  parameter int RAM_WAIT     = 0,
  parameter int IO_WAIT      = 4,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic AS_n,
  input  logic BOOT,
  input  logic ROM_SEL,
  input  logic RAM_SEL,
  input  logic IO_SEL,
  input  logic EXT_SEL,
  input  logic EXT_DTACK_n,
  output logic DTACK_n,
  output logic BERR_n,
  output logic BUSY
);

  localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
  localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

`ifdef BERR_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_EXTW = 3'd2,
    ST_ACK  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EXTW = 2'd2,
    ST_ACK  = 2'd3
  } state_t;
`endif

  state_t     state, state_nx;
  logic [3:0] wcnt, wcnt_nx;
  // Set for EXT-region cycles; clear for unmapped cycles so that a stray
  // EXT_DTACK_n cannot acknowledge an access nobody decoded.
  logic       ext_cycle, ext_cycle_nx;
  logic       dtack_n_r;
  logic       busy_r;

`ifdef BERR_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(BERR_TIMEOUT - 1);

  logic [7:0] tcnt, tcnt_nx;
  logic       berr_n_r;
  logic       timeout;

  // tcnt holds (clocks since cycle start - 1) while in WAIT/EXTW, so the
  // match at BERR_TIMEOUT-1 lands the ERR edge at N+BERR_TIMEOUT.
  assign timeout = (tcnt == TIMEOUT_LAST);
`else
  // Keeps the timeout parameter referenced in builds without the feature.
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(BERR_TIMEOUT);
`endif

  //----------------------------------------------------------------------------
  // Next-state logic
  //----------------------------------------------------------------------------
  always_comb begin
    state_nx     = state;
    wcnt_nx      = wcnt;
    ext_cycle_nx = ext_cycle;
`ifdef BERR_TIMEOUT_EN
    tcnt_nx      = tcnt;
`endif

    case (state)
      ST_IDLE: begin
        if (!AS_n) begin
`ifdef BERR_TIMEOUT_EN
          tcnt_nx = 8'd0;
`endif
          ext_cycle_nx = 1'b0;
          // Boot phase forces ROM timing regardless of the decode.
          if (!BOOT || ROM_SEL) begin
            state_nx = ST_WAIT;
            wcnt_nx  = ROM_WAIT_C;
          end else if (RAM_SEL) begin
            state_nx = ST_WAIT;
            wcnt_nx  = RAM_WAIT_C;
          end else if (IO_SEL) begin
            state_nx = ST_WAIT;
            wcnt_nx  = IO_WAIT_C;
          end else begin
            state_nx     = ST_EXTW;
            ext_cycle_nx = EXT_SEL;
          end
        end
      end

      ST_WAIT: begin
`ifdef BERR_TIMEOUT_EN
        if (tcnt != 8'hFF) begin
          tcnt_nx = tcnt + 8'd1;
        end
`endif
        // Early strobe release aborts before any ack can be issued; a
        // terminating ack takes precedence over a simultaneous timeout.
        if (AS_n) begin
          state_nx = ST_IDLE;
        end else if (wcnt == 4'd0) begin
          state_nx = ST_ACK;
`ifdef BERR_TIMEOUT_EN
        end else if (timeout) begin
          state_nx = ST_ERR;
`endif
        end else begin
          wcnt_nx = wcnt - 4'd1;
        end
      end

      ST_EXTW: begin
`ifdef BERR_TIMEOUT_EN
        if (tcnt != 8'hFF) begin
          tcnt_nx = tcnt + 8'd1;
        end
`endif
        if (AS_n) begin
          state_nx = ST_IDLE;
        end else if (ext_cycle && !EXT_DTACK_n) begin
          state_nx = ST_ACK;
`ifdef BERR_TIMEOUT_EN
        end else if (timeout) begin
          state_nx = ST_ERR;
`endif
        end
      end

      ST_ACK: begin
        if (AS_n) begin
          state_nx = ST_IDLE;
        end
      end

`ifdef BERR_TIMEOUT_EN
      ST_ERR: begin
        if (AS_n) begin
          state_nx = ST_IDLE;
        end
      end
`endif

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // State and output registers. The strobes are decoded from the next state
  // so they change on the same edge as the state itself.
  //----------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state     <= ST_IDLE;
      wcnt      <= 4'd0;
      ext_cycle <= 1'b0;
      dtack_n_r <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      ext_cycle <= ext_cycle_nx;
      dtack_n_r <= (state_nx != ST_ACK);
      busy_r    <= (state_nx != ST_IDLE);
    end
  end

`ifdef BERR_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      tcnt     <= 8'd0;
      berr_n_r <= 1'b1;
    end else begin
      tcnt     <= tcnt_nx;
      berr_n_r <= (state_nx != ST_ERR);
    end
  end

  assign BERR_n = berr_n_r;
`else
  assign BERR_n = 1'b1;
`endif

  assign DTACK_n = dtack_n_r;
  assign BUSY    = busy_r;

endmodule

`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_cycle_ctrl
// Purpose  : Directed self-checking bench for bus_cycle_ctrl with default
//            parameters (ROM_WAIT=2, RAM_WAIT=0, IO_WAIT=4, BERR_TIMEOUT=64).
//            Inputs change 1 ns after a rising edge and outputs are sampled
//            at the same point, so each check sees the edge just taken.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_cycle_ctrl;

  logic CLK = 1'b0;
  logic RESET_n;
  logic AS_n;
  logic BOOT;
  logic ROM_SEL;
  logic RAM_SEL;
  logic IO_SEL;
  logic EXT_SEL;
  logic EXT_DTACK_n;
  logic DTACK_n;
  logic BERR_n;
  logic BUSY;

  int checks = 0;
  int errors = 0;

  bus_cycle_ctrl #(
    .ROM_WAIT    (2),
    .RAM_WAIT    (0),
    .IO_WAIT     (4),
    .BERR_TIMEOUT(64)
  ) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .AS_n       (AS_n),
    .BOOT       (BOOT),
    .ROM_SEL    (ROM_SEL),
    .RAM_SEL    (RAM_SEL),
    .IO_SEL     (IO_SEL),
    .EXT_SEL    (EXT_SEL),
    .EXT_DTACK_n(EXT_DTACK_n),
    .DTACK_n    (DTACK_n),
    .BERR_n     (BERR_n),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic sel(input logic rom, input logic ram, input logic io, input logic ext);
    ROM_SEL = rom;
    RAM_SEL = ram;
    IO_SEL  = io;
    EXT_SEL = ext;
  endtask

  initial begin
    RESET_n     = 1'b0;
    AS_n        = 1'b0;
    BOOT        = 1'b1;
    EXT_DTACK_n = 1'b1;
    sel(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset held two clocks with the strobe already low.
    tick(2);
    check("reset_dtack", DTACK_n, 1'b1);
    check("reset_berr",  BERR_n,  1'b1);
    check("reset_busy",  BUSY,    1'b0);

    // Release: RAM cycle, zero wait -> DTACK_n at N+1.
    RESET_n = 1'b1;
    tick(1);                                   // edge N
    check("ram_busy_n",  BUSY,    1'b1);
    check("ram_dtack_n", DTACK_n, 1'b1);
    tick(1);                                   // N+1
    check("ram_dtack_n1", DTACK_n, 1'b0);
    check("ram_berr_n1",  BERR_n,  1'b1);
    AS_n = 1'b1;
    tick(1);
    check("ram_end_dtack", DTACK_n, 1'b1);
    check("ram_end_busy",  BUSY,    1'b0);

    // Boot override: RAM decode but ROM timing (2 waits) -> ack at N+3.
    BOOT = 1'b0;
    AS_n = 1'b0;
    tick(1);                                   // N
    BOOT = 1'b1;                               // mid-cycle change ignored
    tick(2);                                   // N+2
    check("boot_dtack_n2", DTACK_n, 1'b1);
    tick(1);                                   // N+3
    check("boot_dtack_n3", DTACK_n, 1'b0);
    tick(2);                                   // N+5
    check("boot_hold_n5",  DTACK_n, 1'b0);
    AS_n = 1'b1;
    tick(1);                                   // N+6
    check("boot_end_dtack", DTACK_n, 1'b1);
    check("boot_end_busy",  BUSY,    1'b0);

    // Priority: IO beats EXT, EXT_DTACK_n ignored, 4 waits -> ack at N+5.
    sel(1'b0, 1'b0, 1'b1, 1'b1);
    EXT_DTACK_n = 1'b0;
    AS_n        = 1'b0;
    tick(1);                                   // N
    sel(1'b0, 1'b0, 1'b0, 1'b0);               // selects ignored after latch
    tick(4);                                   // N+4
    check("io_dtack_n4", DTACK_n, 1'b1);
    tick(1);                                   // N+5
    check("io_dtack_n5", DTACK_n, 1'b0);
    AS_n        = 1'b1;
    EXT_DTACK_n = 1'b1;
    tick(1);
    check("io_end_dtack", DTACK_n, 1'b1);

    // External ack sampled at N+7 -> DTACK_n at N+7.
    sel(1'b0, 1'b0, 1'b0, 1'b1);
    AS_n = 1'b0;
    tick(1);                                   // N
    sel(1'b0, 1'b0, 1'b0, 1'b0);
    tick(6);                                   // N+6
    check("ext_dtack_n6", DTACK_n, 1'b1);
    check("ext_busy_n6",  BUSY,    1'b1);
    EXT_DTACK_n = 1'b0;
    tick(1);                                   // N+7
    check("ext_dtack_n7", DTACK_n, 1'b0);
    EXT_DTACK_n = 1'b1;
    AS_n        = 1'b1;
    tick(1);
    check("ext_end_dtack", DTACK_n, 1'b1);
    check("ext_end_busy",  BUSY,    1'b0);

    // Early release of an IO cycle at N+2: no strobe, idle at N+2.
    sel(1'b0, 1'b0, 1'b1, 1'b0);
    AS_n = 1'b0;
    tick(2);                                   // N+1
    AS_n = 1'b1;
    tick(1);                                   // N+2
    check("abort_busy_n2",  BUSY,    1'b0);
    check("abort_dtack_n2", DTACK_n, 1'b1);
    tick(4);
    check("abort_dtack_late", DTACK_n, 1'b1);
    sel(1'b0, 1'b0, 1'b0, 1'b0);

    // Unmapped cycle; a stray EXT_DTACK_n must not acknowledge it.
    EXT_DTACK_n = 1'b0;
    AS_n        = 1'b0;
    tick(1);                                   // N
`ifdef BERR_TIMEOUT_EN
    tick(63);                                  // N+63
    check("unmap_berr_n63",  BERR_n,  1'b1);
    tick(1);                                   // N+64
    check("unmap_berr_n64",  BERR_n,  1'b0);
    check("unmap_dtack_n64", DTACK_n, 1'b1);
    tick(5);
    check("unmap_berr_hold", BERR_n,  1'b0);
    AS_n = 1'b1;
    tick(1);
    check("unmap_end_berr", BERR_n, 1'b1);
`else
    for (int i = 0; i < 300; i++) begin
      tick(1);
      check("unmap_dtack", DTACK_n, 1'b1);
      check("unmap_berr",  BERR_n,  1'b1);
    end
    check("unmap_busy", BUSY, 1'b1);
    AS_n = 1'b1;
    tick(1);
`endif
    check("unmap_end_busy", BUSY, 1'b0);
    EXT_DTACK_n = 1'b1;

    // EXT ack at N+63, just before the timeout edge.
    sel(1'b0, 1'b0, 1'b0, 1'b1);
    AS_n = 1'b0;
    tick(1);                                   // N
    sel(1'b0, 1'b0, 1'b0, 1'b0);
    tick(62);                                  // N+62
    check("race63_dtack_n62", DTACK_n, 1'b1);
    EXT_DTACK_n = 1'b0;
    tick(1);                                   // N+63
    check("race63_dtack", DTACK_n, 1'b0);
    check("race63_berr",  BERR_n,  1'b1);
    EXT_DTACK_n = 1'b1;
    AS_n        = 1'b1;
    tick(1);

    // EXT ack coinciding with the timeout edge N+64: ack wins.
    sel(1'b0, 1'b0, 1'b0, 1'b1);
    AS_n = 1'b0;
    tick(1);                                   // N
    sel(1'b0, 1'b0, 1'b0, 1'b0);
    tick(63);                                  // N+63
    EXT_DTACK_n = 1'b0;
    tick(1);                                   // N+64
    check("race64_dtack", DTACK_n, 1'b0);
    check("race64_berr",  BERR_n,  1'b1);
    EXT_DTACK_n = 1'b1;
    AS_n        = 1'b1;
    tick(1);

    // Reset mid-cycle: aborts with no ack.
    sel(1'b0, 1'b0, 1'b1, 1'b0);
    AS_n = 1'b0;
    tick(2);                                   // N+1
    RESET_n = 1'b0;
    AS_n    = 1'b1;
    tick(1);
    check("midrst_busy",  BUSY,    1'b0);
    check("midrst_dtack", DTACK_n, 1'b1);
    RESET_n = 1'b1;
    tick(6);
    check("midrst_after_dtack", DTACK_n, 1'b1);
    check("midrst_after_busy",  BUSY,    1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
